hs_cdc_pulse_pacer: RTL and testbench

Source-side event pacer that feeds a pulse CDC synchronizer. It accepts event pulses at up to one per clock and counts them in a saturating pending counter. It then re-emits them as single-cycle pulses spaced at least MIN_GAP idle cycles apart, so the downstream synchronizer never sees pulses faster than it can transfer them. Overflow is sticky until cleared.

---
 rtl/hs_cdc_pulse_pacer.sv | 108 ++++++++++
 tb/tb_hs_cdc_pulse_pacer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/hs_cdc_pulse_pacer.sv
// Source-side event pacer ahead of a pulse CDC synchronizer: counts incoming events (saturating)
// and re-emits them as single-cycle pulses separated by at least MIN_GAP inactive cycles.
package hs_cdc_pulse_pacer_pkg;
  typedef enum logic {LEVEL_LOW = 1'b0, LEVEL_HIGH = 1'b1} level_e;
endpackage

module hs_cdc_pulse_pacer
  import hs_cdc_pulse_pacer_pkg::*;
#(
  parameter level_e      ACTIVE_LEVEL = LEVEL_HIGH,
  parameter int unsigned CNT_WIDTH    = 8,
  parameter int unsigned MIN_GAP      = 4
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 pulse_in,
  input  logic                 flush,
  input  logic                 overflow_sclr,
  output logic                 pulse_out,
  output logic [CNT_WIDTH-1:0] pend_cnt,
  output logic                 overflow,
  output logic                 busy
);
  localparam int unsigned          GAP_W    = $clog2(MIN_GAP + 1);
  localparam logic                 ACT      = ACTIVE_LEVEL;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [GAP_W-1:0]     GAP_LOAD = GAP_W'(MIN_GAP - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_GAP} state_e;

  state_e               state_q, state_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [CNT_WIDTH-1:0] pend_q, pend_d;
  logic                 ovf_q, ovf_d;
  logic                 pulse_q;
  logic                 ev, iss, pend_nz;

  assign ev      = (pulse_in == ACT);
  assign pend_nz = (pend_q != '0);

  // Issue decisions look only at the registered count; flush vetoes a new issue.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    iss     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_nz && !flush) begin
          state_d = ST_EMIT;
          iss     = 1'b1;
        end
      end
      ST_EMIT: begin
        state_d = ST_GAP;
        gap_d   = GAP_LOAD;
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          if (pend_nz && !flush) begin
            state_d = ST_EMIT;
            iss     = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // An event coinciding with an issue is a net no-op, so it never drops even at saturation.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (flush) begin
      pend_d = '0;
    end else if (ev && !iss) begin
      if (pend_q == CNT_MAX) ovf_d = 1'b1;
      else                   pend_d = pend_q + 1'b1;
    end else if (!ev && iss) begin
      pend_d = pend_q - 1'b1;
    end
    if (overflow_sclr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      pulse_q <= ~ACT;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      pulse_q <= (state_d == ST_EMIT) ? ACT : ~ACT;
    end
  end

  assign pulse_out = pulse_q;
  assign pend_cnt  = pend_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != ST_IDLE) || pend_nz;
endmodule

// File: tb/tb_hs_cdc_pulse_pacer.sv
// Bench for hs_cdc_pulse_pacer (active-low pulses, 3-bit counter, MIN_GAP=4): directed
// scenarios followed by randomized traffic, all compared against a timestamp-based model.
module tb_hs_cdc_pulse_pacer;
  import hs_cdc_pulse_pacer_pkg::*;

  localparam int CW   = 3;
  localparam int GAP  = 4;
  localparam int MAXP = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic          pulse_in = 1'b1;
  logic          flush = 1'b0;
  logic          overflow_sclr = 1'b0;
  logic          pulse_out;
  logic [CW-1:0] pend_cnt;
  logic          overflow;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model: pending count, sticky overflow, and the edge number of the most recent issue.
  int edge_n  = 0;
  int m_pend  = 0;
  int m_last  = -1000;
  bit m_ovf   = 1'b0;
  bit m_pulse = 1'b0;

  hs_cdc_pulse_pacer #(
    .ACTIVE_LEVEL (LEVEL_LOW),
    .CNT_WIDTH    (CW),
    .MIN_GAP      (GAP)
  ) dut (
    .clk           (clk),
    .srst          (srst),
    .pulse_in      (pulse_in),
    .flush         (flush),
    .overflow_sclr (overflow_sclr),
    .pulse_out     (pulse_out),
    .pend_cnt      (pend_cnt),
    .overflow      (overflow),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, edge_n, got, exp);
    end
  endtask

  // A pulse may be issued once the previous one is at least GAP+1 edges old,
  // provided events were pending before this edge and no flush is present.
  task automatic model_edge(input bit rst, input bit ev, input bit fl, input bit sc);
    bit iss;
    bit drop;
    edge_n++;
    if (rst) begin
      m_pend  = 0;
      m_last  = -1000;
      m_ovf   = 1'b0;
      m_pulse = 1'b0;
    end else begin
      iss  = (m_pend > 0) && !fl && (edge_n - m_last >= GAP + 1);
      drop = 1'b0;
      if (fl) m_pend = 0;
      else begin
        if (ev) m_pend++;
        if (iss) m_pend--;
        if (m_pend > MAXP) begin
          m_pend = MAXP;
          drop   = 1'b1;
        end
      end
      if (sc) m_ovf = 1'b0;
      else if (drop) m_ovf = 1'b1;
      if (iss) m_last = edge_n;
      m_pulse = iss;
    end
  endtask

  task automatic step(input bit rst, input bit ev, input bit fl, input bit sc);
    @(negedge clk);
    srst          = rst;
    pulse_in      = ev ? 1'b0 : 1'b1;
    flush         = fl;
    overflow_sclr = sc;
    @(posedge clk);
    model_edge(rst, ev, fl, sc);
    #1;
    check_val("pulse_out", 32'(pulse_out), m_pulse ? 32'd0 : 32'd1);
    check_val("pend_cnt", 32'(pend_cnt), 32'(m_pend));
    check_val("overflow", 32'(overflow), 32'(m_ovf));
    check_val("busy", 32'(busy), ((edge_n - m_last <= GAP) || (m_pend > 0)) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int dens;
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0);
    // Single event, then drain.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);
    // Long burst saturates the counter, then clear overflow while still dropping.
    repeat (12) step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (45) step(1'b0, 1'b0, 1'b0, 1'b0);
    // Flush with an event while a GAP is running.
    repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b0, 1'b0);
    // Reset mid-GAP with events pending.
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b0, 1'b0);
    // Random traffic in blocks of varying event density.
    for (int blk = 0; blk < 16; blk++) begin
      case (blk % 4)
        0:       dens = 10;
        1:       dens = 40;
        2:       dens = 80;
        default: dens = 100;
      endcase
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(199) == 0,
             $urandom_range(99) < dens,
             $urandom_range(49) == 0,
             $urandom_range(19) == 0);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
